// File: rtl/pa_step_pkg.sv
// Shared types and constants for the 6-step PA step scheduler.
package pa_step_pkg;
  typedef logic [2:0] step_t;

  localparam step_t STEP_OFF  = 3'd7;
  localparam step_t STEP_LAST = 3'd5;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} sched_state_t;

  function automatic step_t next_step(input step_t s);
    return (s == STEP_LAST) ? step_t'(3'd0) : step_t'(s + 3'd1);
  endfunction
endpackage

// File: rtl/pa_phase_acc.sv
// Phase accumulator with shadow/active tuning word; carry-out is the step tick.
module pa_phase_acc #(
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               i_clear,
  input  logic [PHASE_W-1:0] i_ftw,
  input  logic               i_ftwLoad,
  input  logic               i_loadActive,
  output logic               o_tick
);
  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_shadow;
  logic [PHASE_W-1:0] r_active;
  logic [PHASE_W:0]   w_sum;

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_active};
  assign o_tick = w_sum[PHASE_W] & ~i_clear;

  // Active word only moves on cycle boundaries, so it reads the shadow's
  // pre-edge value when a load and a wrap coincide.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_acc    <= '0;
      r_shadow <= '0;
      r_active <= '0;
    end else begin
      if (i_ftwLoad)    r_shadow <= i_ftw;
      if (i_loadActive) r_active <= r_shadow;
      r_acc <= i_clear ? '0 : w_sum[PHASE_W-1:0];
    end
  end
endmodule

// File: rtl/pa_step_scheduler.sv
// Step sequencer for the 6-step MOSFET decoder: NCO-paced steps, dead time,
// whole-cycle keying. Outputs are a registered view of the internal state.
module pa_step_scheduler
  import pa_step_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int DEAD_W  = 4
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               txEnable,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftwLoad,
  input  logic [DEAD_W-1:0]  deadCycles,
  output logic [2:0]         stepIndex,
  output logic               cycleStart,
  output logic               running,
  output logic               overrun
);
  sched_state_t      r_state, w_stateNxt;
  step_t             r_step, w_stepNxt;
  logic [DEAD_W-1:0] r_dead, w_deadNxt;
  logic              r_stopPend, w_stopNxt;
  logic              r_overrun, w_ovrNxt;
  logic              r_new0, w_new0;
  logic              w_loadActive;
  logic              w_tick;
  step_t             r_stepIndex;
  logic              r_cycleStart;
  logic              r_running;

  pa_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
    .clk          (clk),
    .rstN         (rstN),
    .i_clear      (r_state == IDLE),
    .i_ftw        (ftw),
    .i_ftwLoad    (ftwLoad),
    .i_loadActive (w_loadActive),
    .o_tick       (w_tick)
  );

  always_comb begin
    w_stateNxt   = r_state;
    w_stepNxt    = r_step;
    w_deadNxt    = r_dead;
    w_stopNxt    = r_stopPend;
    w_ovrNxt     = r_overrun;
    w_new0       = 1'b0;
    w_loadActive = 1'b0;
    case (r_state)
      IDLE: begin
        w_stopNxt = 1'b0;
        if (txEnable) begin
          w_stateNxt   = RUN;
          w_stepNxt    = '0;
          w_ovrNxt     = 1'b0;
          w_new0       = 1'b1;
          w_loadActive = 1'b1;
        end
      end
      RUN: begin
        w_stopNxt = ~txEnable;
        if (w_tick) begin
          if (r_step == STEP_LAST && r_stopPend) begin
            w_stateNxt = IDLE;
            w_stopNxt  = 1'b0;
          end else if (deadCycles == '0) begin
            w_stepNxt    = next_step(r_step);
            w_new0       = (r_step == STEP_LAST);
            w_loadActive = (r_step == STEP_LAST);
          end else begin
            w_stateNxt = DEAD;
            w_deadNxt  = deadCycles;
          end
        end
      end
      DEAD: begin
        w_stopNxt = ~txEnable;
        // The NCO is too fast for the dead time; the tick is lost.
        if (w_tick) w_ovrNxt = 1'b1;
        if (r_dead <= 1) begin
          w_stateNxt   = RUN;
          w_stepNxt    = next_step(r_step);
          w_new0       = (r_step == STEP_LAST);
          w_loadActive = (r_step == STEP_LAST);
        end else begin
          w_deadNxt = r_dead - 1'b1;
        end
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state      <= IDLE;
      r_step       <= '0;
      r_dead       <= '0;
      r_stopPend   <= 1'b0;
      r_overrun    <= 1'b0;
      r_new0       <= 1'b0;
      r_stepIndex  <= STEP_OFF;
      r_cycleStart <= 1'b0;
      r_running    <= 1'b0;
    end else begin
      r_state      <= w_stateNxt;
      r_step       <= w_stepNxt;
      r_dead       <= w_deadNxt;
      r_stopPend   <= w_stopNxt;
      r_overrun    <= w_ovrNxt;
      r_new0       <= w_new0;
      r_stepIndex  <= (r_state == RUN) ? r_step : STEP_OFF;
      r_cycleStart <= r_new0;
      r_running    <= (r_state != IDLE);
    end
  end

  assign stepIndex  = r_stepIndex;
  assign cycleStart = r_cycleStart;
  assign running    = r_running;
  assign overrun    = r_overrun;
endmodule

// File: tb/tb_pa_step_scheduler.sv
// Directed + randomized bench; expected step/dead segment lengths come from
// the step period (2^32/ftw clocks) and the dead count.
module tb_pa_step_scheduler;
  localparam int PW = 32;
  localparam int DW = 4;
  localparam int LIMIT = 4000;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          txEnable = 1'b0;
  logic [PW-1:0] ftw = '0;
  logic          ftwLoad = 1'b0;
  logic [DW-1:0] deadCycles = '0;
  logic [2:0]    stepIndex;
  logic          cycleStart, running, overrun;

  int checks = 0;
  int errors = 0;
  int six_seen = 0;

  typedef struct {
    logic [2:0] v;
    int         n;
  } seg_t;

  pa_step_scheduler #(.PHASE_W(PW), .DEAD_W(DW)) dut (
    .clk        (clk),
    .rstN       (rstN),
    .txEnable   (txEnable),
    .ftw        (ftw),
    .ftwLoad    (ftwLoad),
    .deadCycles (deadCycles),
    .stepIndex  (stepIndex),
    .cycleStart (cycleStart),
    .running    (running),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rstN && stepIndex == 3'd6) six_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_ftw(input logic [PW-1:0] f);
    ftw = f;
    ftwLoad = 1'b1;
    cyc(1);
    ftwLoad = 1'b0;
  endtask

  // Length of the current run of identical stepIndex samples.
  task automatic run_len(output logic [2:0] v, output int n);
    v = stepIndex;
    n = 0;
    while (stepIndex === v && n < LIMIT) begin
      cyc(1);
      n++;
    end
  endtask

  task automatic seg(input string tag, input logic [2:0] ev, input int elen);
    logic [2:0] v;
    int n;
    run_len(v, n);
    chk({tag, " val"}, {29'd0, v}, {29'd0, ev});
    chk({tag, " len"}, n, elen);
  endtask

  task automatic seek_entry(input logic [2:0] v);
    int n = 0;
    while (stepIndex === v && n < LIMIT) begin cyc(1); n++; end
    while (stepIndex !== v && n < LIMIT) begin cyc(1); n++; end
    chk("seek", {29'd0, stepIndex}, {29'd0, v});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (running !== 1'b0 && n < LIMIT) begin cyc(1); n++; end
    chk("idle", {31'd0, running}, 32'd0);
  endtask

  // Reference: one full cycle at period P clocks/step with d dead clocks per change.
  task automatic check_cycle(input string tag, input int P, input int d);
    seg_t q[$];
    for (int k = 0; k < 6; k++) begin
      q.push_back('{3'(k), P - d});
      if (d > 0) q.push_back('{3'd7, d});
    end
    foreach (q[i]) begin
      chk({tag, " cs"}, {31'd0, cycleStart}, {31'd0, (i == 0)});
      seg(tag, q[i].v, q[i].n);
    end
  endtask

  initial begin
    logic [63:0] full;
    int P, d;
    full = 64'd1 << 32;

    cyc(3);
    chk("rst idx", {29'd0, stepIndex}, 32'd7);
    chk("rst cs", {31'd0, cycleStart}, 32'd0);
    chk("rst run", {31'd0, running}, 32'd0);
    chk("rst ovr", {31'd0, overrun}, 32'd0);

    rstN = 1'b1;
    load_ftw(32'h1000_0000);
    deadCycles = 4'd0;
    cyc(5);
    txEnable = 1'b1;
    cyc(1);
    chk("lat idx", {29'd0, stepIndex}, 32'd7);
    chk("lat run", {31'd0, running}, 32'd0);
    cyc(1);
    chk("start idx", {29'd0, stepIndex}, 32'd0);
    chk("start run", {31'd0, running}, 32'd1);
    check_cycle("c16", 16, 0);

    // Dead time
    deadCycles = 4'd3;
    seek_entry(3'd0);
    check_cycle("dead3", 16, 3);
    deadCycles = 4'd0;

    // Graceful stop
    seek_entry(3'd2);
    txEnable = 1'b0;
    seg("stop s2", 3'd2, 16);
    seg("stop s3", 3'd3, 16);
    seg("stop s4", 3'd4, 16);
    seg("stop s5", 3'd5, 16);
    chk("stop idx", {29'd0, stepIndex}, 32'd7);
    chk("stop run", {31'd0, running}, 32'd0);
    cyc(20);
    chk("stopped idx", {29'd0, stepIndex}, 32'd7);

    // Restart, then cancel a stop before the wrap
    txEnable = 1'b1;
    cyc(2);
    chk("restart idx", {29'd0, stepIndex}, 32'd0);
    chk("restart cs", {31'd0, cycleStart}, 32'd1);
    seek_entry(3'd2);
    txEnable = 1'b0;
    seek_entry(3'd4);
    txEnable = 1'b1;
    seg("cancel s4", 3'd4, 16);
    seg("cancel s5", 3'd5, 16);
    chk("cancel idx", {29'd0, stepIndex}, 32'd0);
    chk("cancel cs", {31'd0, cycleStart}, 32'd1);

    // Mid-cycle FTW load applies only from the next cycle
    seek_entry(3'd2);
    load_ftw(32'h0800_0000);
    seg("ftw s2", 3'd2, 15);
    seg("ftw s3", 3'd3, 16);
    seg("ftw s4", 3'd4, 16);
    seg("ftw s5", 3'd5, 16);
    check_cycle("c32", 32, 0);

    // Randomized rates and dead times
    for (int r = 0; r < 6; r++) begin
      P = 16 << $urandom_range(0, 2);
      d = $urandom_range(0, 7);
      load_ftw(32'(full / 64'(P)));
      deadCycles = DW'(d);
      seek_entry(3'd0);
      seek_entry(3'd0);
      check_cycle($sformatf("rnd P%0d d%0d", P, d), P, d);
      chk("rnd ovr", {31'd0, overrun}, 32'd0);
    end

    // Overrun: sticky through idle, cleared by a start
    txEnable = 1'b0;
    wait_idle();
    load_ftw(32'h8000_0000);
    deadCycles = 4'd4;
    txEnable = 1'b1;
    cyc(10);
    chk("ovr set", {31'd0, overrun}, 32'd1);
    txEnable = 1'b0;
    wait_idle();
    chk("ovr sticky", {31'd0, overrun}, 32'd1);
    load_ftw(32'h1000_0000);
    deadCycles = 4'd0;
    txEnable = 1'b1;
    cyc(1);
    chk("ovr clr", {31'd0, overrun}, 32'd0);

    // Reset mid-step while overrun is set
    load_ftw(32'h8000_0000);
    deadCycles = 4'd4;
    seek_entry(3'd0);
    seek_entry(3'd4);
    chk("ovr again", {31'd0, overrun}, 32'd1);
    rstN = 1'b0;
    cyc(1);
    chk("mrst idx", {29'd0, stepIndex}, 32'd7);
    chk("mrst run", {31'd0, running}, 32'd0);
    chk("mrst ovr", {31'd0, overrun}, 32'd0);
    chk("mrst cs", {31'd0, cycleStart}, 32'd0);
    cyc(10);
    chk("mrst hold", {29'd0, stepIndex}, 32'd7);

    // Shadow was cleared by reset: zero rate holds step 0
    rstN = 1'b1;
    cyc(2);
    chk("static idx", {29'd0, stepIndex}, 32'd0);
    chk("static cs", {31'd0, cycleStart}, 32'd1);
    cyc(30);
    chk("static hold", {29'd0, stepIndex}, 32'd0);
    chk("static cs0", {31'd0, cycleStart}, 32'd0);
    chk("static run", {31'd0, running}, 32'd1);

    chk("no step 6", six_seen, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
